// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: non-speculative fetch stage owning the PC, one request in flight,
// instruction register toward decode. Optional misaligned-redirect trap: IFU_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [6:0]      op,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   input  logic            pc_src,
   input  logic [XLEN-1:0] pc_target,
`ifdef IFU_MISALIGN_TRAP_EN
   output logic            misalign_trap,
`endif
   output logic [31:0]     instr_count
);

   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(3'd4);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(2'b11));
   localparam logic [31:0]     NOP_INSTR  = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
`ifdef IFU_MISALIGN_TRAP_EN
      S_HALT  = 3'd4,
`endif
      S_VALID = 3'd3
   } state_t;

   state_t          state_r;
   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] next_pc_s;

   // Next PC for an accepted instruction: redirect target or sequential, wrapping naturally.
   always_comb begin
      if (pc_src) begin
`ifdef IFU_MISALIGN_TRAP_EN
         next_pc_s = pc_target;
`else
         next_pc_s = pc_target & ALIGN_MASK;
`endif
      end else begin
         next_pc_s = pc_r + PC_STEP;
      end
   end

`ifdef IFU_MISALIGN_TRAP_EN
   logic misalign_s;
   assign misalign_s = pc_src && (pc_target[1:0] != 2'b00);
`endif

   assign op     = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // Fetch FSM with all handshake outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= S_IDLE;
         pc_r        <= RESET_PC;
         imem_req    <= 1'b0;
         imem_addr   <= RESET_PC;
         instr       <= NOP_INSTR;
         instr_pc    <= RESET_PC;
         instr_valid <= 1'b0;
         instr_count <= 32'd0;
`ifdef IFU_MISALIGN_TRAP_EN
         misalign_trap <= 1'b0;
`endif
      end else begin
         case (state_r)
            S_IDLE: begin
               state_r   <= S_REQ;
               imem_req  <= 1'b1;
               imem_addr <= pc_r;
            end
            S_REQ: begin
               if (imem_gnt) begin
                  state_r  <= S_WAIT;
                  imem_req <= 1'b0;
               end
            end
            S_WAIT: begin
               // Only data returned while waiting belongs to our single outstanding request.
               if (imem_rvalid) begin
                  state_r     <= S_VALID;
                  instr       <= imem_rdata;
                  instr_pc    <= pc_r;
                  instr_valid <= 1'b1;
               end
            end
            S_VALID: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  instr_count <= instr_count + 32'd1;
`ifdef IFU_MISALIGN_TRAP_EN
                  if (misalign_s) begin
                     state_r       <= S_HALT;
                     misalign_trap <= 1'b1;
                  end else begin
                     state_r   <= S_REQ;
                     pc_r      <= next_pc_s;
                     imem_req  <= 1'b1;
                     imem_addr <= next_pc_s;
                  end
`else
                  state_r   <= S_REQ;
                  pc_r      <= next_pc_s;
                  imem_req  <= 1'b1;
                  imem_addr <= next_pc_s;
`endif
               end
            end
`ifdef IFU_MISALIGN_TRAP_EN
            S_HALT: begin
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
`endif
            default: begin
               state_r     <= S_IDLE;
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: memory responder, decode driver with a
// program-flow reference model, and an independent monitor. Build with IFU_MISALIGN_TRAP_EN to test the trap.
module tb_instr_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        instr_valid, instr_ready;
   logic [31:0] instr, instr_pc, pc_target, instr_count;
   logic [6:0]  op, funct7;
   logic [2:0]  funct3;
   logic        pc_src;
`ifdef IFU_MISALIGN_TRAP_EN
   logic        misalign_trap;
`endif

   always #5 clk = ~clk;

   instr_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc), .op(op), .funct3(funct3), .funct7(funct7),
      .pc_src(pc_src), .pc_target(pc_target),
`ifdef IFU_MISALIGN_TRAP_EN
      .misalign_trap(misalign_trap),
`endif
      .instr_count(instr_count)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } item_t;

   item_t       exp_q[$];
   logic [31:0] mem [logic [31:0]];
   logic [31:0] model_pc;
   logic [31:0] model_cnt = 32'd0;
   logic        model_trap = 1'b0;
   int          total = 0;
   int          bad = 0;

   // knobs, written only by the main process
   int          gnt_lo = 0, gnt_hi = 0, rv_lo = 0, rv_hi = 0;
   bit          junk_en = 1'b0;
   int          ready_mode = 0;
   bit          use_force = 1'b0;
   logic        f_src = 1'b0;
   logic [31:0] f_tgt = 32'd0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (!mem.exists(a)) mem[a] = $urandom;
      return mem[a];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // memory responder: one request at a time, random gnt/rvalid latency, stale return after reset
   initial begin
      bit          out_r = 1'b0, stale = 1'b0, req_seen = 1'b0;
      int          gw = 0, rw = 0;
      logic [31:0] a = 32'd0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
      forever begin
         @(negedge clk); #1;
         imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = $urandom;
         if (reset) begin
            if (out_r) stale = 1'b1;
            out_r = 1'b0; req_seen = 1'b0;
         end else if (stale) begin
            imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; stale = 1'b0;
         end else if (out_r) begin
            if (rw == 0) begin
               imem_rvalid = 1'b1; imem_rdata = mem_word(a); out_r = 1'b0;
            end else rw--;
         end else if (imem_req) begin
            if (!req_seen) begin req_seen = 1'b1; gw = $urandom_range(gnt_hi, gnt_lo); end
            if (gw == 0) begin
               imem_gnt = 1'b1; a = imem_addr; out_r = 1'b1; req_seen = 1'b0;
               rw = $urandom_range(rv_hi, rv_lo);
            end else gw--;
         end else if (junk_en && $urandom_range(3, 0) == 0) begin
            imem_gnt = ($urandom_range(1, 0) == 1);
            imem_rvalid = !imem_gnt;
         end
      end
   end

   // decode driver + reference model of program flow
   initial begin
      bit          armed = 1'b0;
      logic        a_src = 1'b0;
      logic [31:0] a_tgt = 32'd0, tgt;
      instr_ready = 1'b0; pc_src = 1'b0; pc_target = 32'd0; model_pc = RST_PC;
      forever begin
         @(negedge clk); #1;
         if (armed) begin
            armed = 1'b0;
            model_cnt = model_cnt + 32'd1;
`ifdef IFU_MISALIGN_TRAP_EN
            if (a_src && a_tgt[1:0] != 2'b00) model_trap = 1'b1;
            else begin
               model_pc = a_src ? a_tgt : model_pc + 32'd4;
               exp_q.push_back({model_pc, mem_word(model_pc)});
            end
`else
            model_pc = a_src ? {a_tgt[31:2], 2'b00} : model_pc + 32'd4;
            exp_q.push_back({model_pc, mem_word(model_pc)});
`endif
         end
         if (reset) begin
            model_cnt = 32'd0; model_trap = 1'b0; model_pc = RST_PC;
            exp_q = {};
            exp_q.push_back({RST_PC, mem_word(RST_PC)});
         end
         instr_ready = (ready_mode == 2) || (ready_mode == 1 && $urandom_range(1, 0) == 1);
         if (use_force) begin
            pc_src = f_src; pc_target = f_tgt;
         end else begin
            case ($urandom_range(3, 0))
               0:       tgt = 32'hFFFF_FFF8;
               1:       tgt = $urandom_range(255, 0);
               default: tgt = $urandom;
            endcase
`ifdef IFU_MISALIGN_TRAP_EN
            tgt = tgt & 32'hFFFF_FFFC;
`endif
            pc_src = ($urandom_range(2, 0) == 0); pc_target = tgt;
         end
         if (instr_ready && instr_valid && !reset) begin
            armed = 1'b1; a_src = pc_src; a_tgt = pc_target;
         end
      end
   end

   // monitor: pops the scoreboard whenever a new instruction is presented
   initial begin
      bit    pv = 1'b0;
      item_t cur = '0, e;
      forever begin
         @(negedge clk); #2;
         if (reset) pv = 1'b0;
         else begin
            chk("count", instr_count, model_cnt);
`ifdef IFU_MISALIGN_TRAP_EN
            chk("trap", {31'd0, misalign_trap}, {31'd0, model_trap});
`endif
            if (imem_req) begin
               if (exp_q.size() == 0) chk("spurious_req", {31'd0, imem_req}, 32'd0);
               else chk("fetch_addr", imem_addr, exp_q[0].pc);
            end
            if (instr_valid && !pv) begin
               if (exp_q.size() == 0) chk("spurious_valid", {31'd0, instr_valid}, 32'd0);
               else begin
                  e = exp_q.pop_front();
                  cur = e;
                  chk("instr", instr, e.data);
                  chk("instr_pc", instr_pc, e.pc);
                  chk("fields", {9'd0, funct7, funct3, op}, {9'd0, e.data[31:25], e.data[14:12], e.data[6:0]});
               end
            end else if (instr_valid) begin
               chk("hold_instr", instr, cur.data);
               chk("hold_pc", instr_pc, cur.pc);
            end
            pv = instr_valid;
         end
      end
   end

   task automatic nxt();
      @(negedge clk); #3;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk); reset = 1'b1;
      repeat (n) @(negedge clk);
      #3;
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_count", instr_count, 32'd0);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_instr", instr, 32'h0000_0013);
      chk("rst_instr_pc", instr_pc, RST_PC);
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic wait_count(input logic [31:0] target);
      for (int i = 0; i < 60 && instr_count != target; i++) nxt();
      chk("wait_count", instr_count, target);
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 60 && !instr_valid; i++) nxt();
      chk("wait_valid", {31'd0, instr_valid}, 32'd1);
   endtask

   initial begin
      logic [31:0] c;
      reset = 1'b1;
      mem[RST_PC] = 32'h0050_0093;
      do_reset(3);
      // first fetch latency with immediate gnt and rvalid one cycle later
      nxt(); chk("t1_req", {31'd0, imem_req}, 32'd1); chk("t1_addr", imem_addr, 32'h0);
      nxt(); chk("t1_not_yet", {31'd0, instr_valid}, 32'd0);
      nxt(); chk("t1_valid", {31'd0, instr_valid}, 32'd1);
      chk("t1_op", {25'd0, op}, {25'd0, 7'b0010011});
      chk("t1_f3", {29'd0, funct3}, 32'd0);
      chk("t1_pc", instr_pc, 32'h0);
      chk("t1_instr", instr, 32'h0050_0093);
      // decode stall
      for (int i = 0; i < 5; i++) begin
         nxt();
         chk("t4_instr", instr, 32'h0050_0093);
         chk("t4_pc", instr_pc, 32'h0);
         chk("t4_req", {31'd0, imem_req}, 32'd0);
      end
      // sequential accept
      use_force = 1'b1; f_src = 1'b0; f_tgt = 32'h40; ready_mode = 2;
      wait_count(32'd1); ready_mode = 0;
      chk("t2_req", {31'd0, imem_req}, 32'd1); chk("t2_addr", imem_addr, 32'h4);
      // redirect
      wait_valid(); f_src = 1'b1; ready_mode = 2;
      wait_count(32'd2); ready_mode = 0;
      chk("t3_addr", imem_addr, 32'h40);
      wait_valid(); chk("t3_pc", instr_pc, 32'h40);
      // reset while waiting for read data, stale rvalid after reset
      rv_lo = 5; rv_hi = 5; f_src = 1'b0; ready_mode = 2;
      wait_count(32'd3); ready_mode = 0;
      nxt(); chk("t5_in_wait", {30'd0, imem_req, instr_valid}, 32'd0);
      rv_lo = 0; rv_hi = 0;
      do_reset(2);
      nxt();
      chk("t5_valid", {31'd0, instr_valid}, 32'd0); chk("t5_count", instr_count, 32'd0);
      chk("t5_addr", imem_addr, RST_PC);
      wait_valid();
      chk("t5_instr", instr, 32'h0050_0093); chk("t5_pc", instr_pc, RST_PC);
      // randomized traffic
      use_force = 1'b0; gnt_lo = 0; gnt_hi = 3; rv_lo = 0; rv_hi = 3; junk_en = 1'b1; ready_mode = 1;
      for (int i = 0; i < 5000 && model_cnt < 32'd150; i++) nxt();
      chk("progress", {31'd0, (instr_count >= 32'd150)}, 32'd1);
      ready_mode = 0;
      wait_valid();
      // misaligned redirect
      c = instr_count;
      use_force = 1'b1; f_src = 1'b1; f_tgt = 32'h42; ready_mode = 2;
      wait_count(c + 32'd1); ready_mode = 0;
`ifdef IFU_MISALIGN_TRAP_EN
      chk("t6_trap", {31'd0, misalign_trap}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         nxt(); chk("t6_halt", {30'd0, imem_req, instr_valid}, 32'd0);
      end
`else
      chk("t6_req", {31'd0, imem_req}, 32'd1); chk("t6_addr", imem_addr, 32'h40);
      wait_valid(); chk("t6_pc", instr_pc, 32'h40);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
